// File: rtl/ac97_pkg.sv
// Shared AC97 receive-side constants: frame geometry, slot start bits, tag positions, rx state.
package ac97_pkg;

  localparam int FRAME_BITS  = 256;
  localparam int SLOT_BITS   = 20;
  localparam int TAG_BITS    = 5;

  localparam int TAG_START   = 0;
  localparam int SLOT1_START = 16;
  localparam int SLOT2_START = 36;
  localparam int SLOT3_START = 56;
  localparam int SLOT4_START = 76;
  localparam int LAST_DATA_BIT = SLOT4_START + SLOT_BITS - 1;

  // Positions inside the 5-bit tag shift register (first received bit ends up as MSB).
  localparam int TAG_READY = 4;
  localparam int TAG_SLOT1 = 3;
  localparam int TAG_SLOT2 = 2;
  localparam int TAG_SLOT3 = 1;
  localparam int TAG_SLOT4 = 0;

  typedef enum logic {
    UNLOCKED  = 1'b0,
    RECEIVING = 1'b1
  } rx_state_e;

endpackage

// File: rtl/ac97_slot_shifter.sv
// Serial-in shift register that captures WIDTH frame bits starting at frame bit START, MSB first.
module ac97_slot_shifter #(
  parameter int WIDTH = 20,
  parameter int START = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [7:0]       bit_idx_i,
  input  logic             sdata_i,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [7:0] LO  = 8'(START);
  localparam logic [7:0] LEN = 8'(WIDTH);

  logic [7:0]       offset;
  logic [WIDTH-1:0] data_q;

  // Wrapping subtraction makes indices below START land far outside the window.
  assign offset = bit_idx_i - LO;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (en_i && (offset < LEN)) begin
      data_q <= {data_q[WIDTH-2:0], sdata_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/ac97_frame_receiver.sv
// AC97 SDATA_IN deserialiser: record samples (slots 3/4), status (slots 1/2), lock and error tracking.
// Build option: define AC97_RX_STATUS_EN to capture slots 1/2 and drive the status outputs.
module ac97_frame_receiver
  import ac97_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = 18,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     ac97_bit_clock,
  input  logic                     reset,
  input  logic                     ac97_synch,
  input  logic                     ac97_sdata_in,
  output logic [SAMPLE_WIDTH-1:0]  left_sample,
  output logic [SAMPLE_WIDTH-1:0]  right_sample,
  output logic                     sample_valid,
  output logic [7:0]               status_addr,
  output logic [15:0]              status_data,
  output logic                     status_valid,
  output logic                     codec_ready,
  output logic                     locked,
  output logic                     frame_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count
);

  logic                     synch_prev_q;
  rx_state_e                state_q, state_d;
  logic [7:0]               bit_idx_q, bit_idx_d;
  logic [7:0]               cur_idx;
  logic                     sync_rise, sample_en, misalign, sync_loss;
  logic                     frame_done, frame_err, sample_load;

  logic [TAG_BITS-1:0]      tag_q;
  logic [SLOT_BITS-1:0]     slot3_q, slot4_q, slot4_full;

  logic [SAMPLE_WIDTH-1:0]  left_q, right_q;
  logic                     sample_valid_q, codec_ready_q, frame_error_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  // A sync rise always forces the current edge to be frame bit 0, whatever the counter says.
  always_comb begin
    sync_rise = ac97_synch & ~synch_prev_q;
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    cur_idx   = bit_idx_q;
    sample_en = 1'b0;
    misalign  = 1'b0;
    sync_loss = 1'b0;
    if (state_q == UNLOCKED) begin
      if (sync_rise) begin
        state_d   = RECEIVING;
        cur_idx   = 8'd0;
        bit_idx_d = 8'd1;
        sample_en = 1'b1;
      end
    end else if (sync_rise) begin
      misalign  = (bit_idx_q != 8'd0);
      cur_idx   = 8'd0;
      bit_idx_d = 8'd1;
      sample_en = 1'b1;
    end else if (bit_idx_q == 8'd0) begin
      sync_loss = 1'b1;
      state_d   = UNLOCKED;
    end else begin
      sample_en = 1'b1;
      bit_idx_d = bit_idx_q + 8'd1;
    end
  end

  assign frame_done  = sample_en && (cur_idx == 8'(LAST_DATA_BIT));
  assign frame_err   = misalign | sync_loss;
  assign sample_load = frame_done && tag_q[TAG_READY] && tag_q[TAG_SLOT3] && tag_q[TAG_SLOT4];
  // Slot 4 completes on this very edge, so its last bit comes straight from the pin.
  assign slot4_full  = {slot4_q[SLOT_BITS-2:0], ac97_sdata_in};

  ac97_slot_shifter #(.WIDTH(TAG_BITS), .START(TAG_START)) u_tag (
    .clk_i(ac97_bit_clock), .reset_i(reset), .en_i(sample_en),
    .bit_idx_i(cur_idx), .sdata_i(ac97_sdata_in), .data_o(tag_q)
  );
  ac97_slot_shifter #(.WIDTH(SLOT_BITS), .START(SLOT3_START)) u_slot3 (
    .clk_i(ac97_bit_clock), .reset_i(reset), .en_i(sample_en),
    .bit_idx_i(cur_idx), .sdata_i(ac97_sdata_in), .data_o(slot3_q)
  );
  ac97_slot_shifter #(.WIDTH(SLOT_BITS), .START(SLOT4_START)) u_slot4 (
    .clk_i(ac97_bit_clock), .reset_i(reset), .en_i(sample_en),
    .bit_idx_i(cur_idx), .sdata_i(ac97_sdata_in), .data_o(slot4_q)
  );

  always_ff @(posedge ac97_bit_clock or posedge reset) begin
    if (reset) begin
      synch_prev_q   <= 1'b0;
      state_q        <= UNLOCKED;
      bit_idx_q      <= '0;
      left_q         <= '0;
      right_q        <= '0;
      sample_valid_q <= 1'b0;
      codec_ready_q  <= 1'b0;
      frame_error_q  <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      synch_prev_q   <= ac97_synch;
      state_q        <= state_d;
      bit_idx_q      <= bit_idx_d;
      sample_valid_q <= sample_load;
      frame_error_q  <= frame_err;
      if (frame_done) codec_ready_q <= tag_q[TAG_READY];
      if (sample_load) begin
        left_q  <= slot3_q[SLOT_BITS-1 -: SAMPLE_WIDTH];
        right_q <= slot4_full[SLOT_BITS-1 -: SAMPLE_WIDTH];
      end
      if (frame_err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef AC97_RX_STATUS_EN
  logic [SLOT_BITS-1:0] slot1_q, slot2_q;
  logic [7:0]           status_addr_q;
  logic [15:0]          status_data_q;
  logic                 status_valid_q;
  logic                 status_load;

  assign status_load = frame_done && tag_q[TAG_SLOT1] && tag_q[TAG_SLOT2];

  ac97_slot_shifter #(.WIDTH(SLOT_BITS), .START(SLOT1_START)) u_slot1 (
    .clk_i(ac97_bit_clock), .reset_i(reset), .en_i(sample_en),
    .bit_idx_i(cur_idx), .sdata_i(ac97_sdata_in), .data_o(slot1_q)
  );
  ac97_slot_shifter #(.WIDTH(SLOT_BITS), .START(SLOT2_START)) u_slot2 (
    .clk_i(ac97_bit_clock), .reset_i(reset), .en_i(sample_en),
    .bit_idx_i(cur_idx), .sdata_i(ac97_sdata_in), .data_o(slot2_q)
  );

  always_ff @(posedge ac97_bit_clock or posedge reset) begin
    if (reset) begin
      status_addr_q  <= '0;
      status_data_q  <= '0;
      status_valid_q <= 1'b0;
    end else begin
      status_valid_q <= status_load;
      if (status_load) begin
        status_addr_q <= slot1_q[19:12];
        status_data_q <= slot2_q[19:4];
      end
    end
  end

  assign status_addr  = status_addr_q;
  assign status_data  = status_data_q;
  assign status_valid = status_valid_q;

  logic unused_status;
  assign unused_status = ^{slot1_q[11:0], slot2_q[3:0]};
`else
  assign status_addr  = '0;
  assign status_data  = '0;
  assign status_valid = 1'b0;
`endif

  // Low slot bits below SAMPLE_WIDTH, and status tags in the lean build, are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{slot3_q, slot4_full, tag_q};

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = sample_valid_q;
  assign codec_ready  = codec_ready_q;
  assign locked       = (state_q == RECEIVING);
  assign frame_error  = frame_error_q;
  assign error_count  = err_cnt_q;

endmodule
